uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: a circular queue drained by a small
// handshake FSM that issues one write pulse per byte and tracks busy/done.
module uart_tx_feeder #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned NUM_DATA_BITS = 8
) (
    input  logic                     baud,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     push,
    input  logic [NUM_DATA_BITS-1:0] in_data,
    input  logic                     overflow_clr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_enable,
    output logic                     tx_write,
    output logic [NUM_DATA_BITS-1:0] tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    input  logic                     tx_error,
    output logic                     sent_pulse,
    output logic                     stall_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    logic [NUM_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_full;
    logic                     r_empty;
    logic                     r_overflow;

    state_t                   r_state;
    logic                     r_tx_enable;
    logic                     r_tx_write;
    logic [NUM_DATA_BITS-1:0] r_tx_data;
    logic                     r_sent;
    logic                     r_stall;
    logic                     r_busy_miss;

    state_t                   w_state_nxt;
    logic                     w_pop;
    logic                     w_sent;
    logic                     w_stall_set;
    logic                     w_busy_miss_nxt;
    logic                     w_push_acc;
    logic                     w_push_drop;
    logic [CW-1:0]            w_count_nxt;
    logic [AW-1:0]            w_wr_ptr_inc;
    logic [AW-1:0]            w_rd_ptr_inc;

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign w_push_acc  = push & ~r_full;
    assign w_push_drop = push &  r_full;

    assign w_wr_ptr_inc = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge baud) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: dropping enable abandons any in-flight byte.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_sent          = 1'b0;
        w_stall_set     = tx_error;
        w_busy_miss_nxt = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_tx_enable && !r_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_state_nxt = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        w_state_nxt = S_WAIT_DONE;
                    end else if (r_busy_miss) begin
                        w_stall_set = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_busy_miss_nxt = 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done) begin
                        w_sent      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_enable <= 1'b0;
            r_tx_write  <= 1'b0;
            r_tx_data   <= '0;
            r_sent      <= 1'b0;
            r_stall     <= 1'b0;
            r_busy_miss <= 1'b0;
        end else begin
            r_tx_enable <= enable;
            r_tx_write  <= w_pop;
            r_sent      <= w_sent;
            r_busy_miss <= w_busy_miss_nxt;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (w_stall_set) begin
                r_stall <= 1'b1;
            end else if (overflow_clr) begin
                r_stall <= 1'b0;
            end
        end
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign tx_enable  = r_tx_enable;
    assign tx_write   = r_tx_write;
    assign tx_data    = r_tx_data;
    assign sent_pulse = r_sent;
    assign stall_err  = r_stall;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus queues expected bytes, a monitor
// checks every transmitter write in order, and a small transmitter model responds.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned NB    = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          baud = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          push = 1'b0;
    logic [NB-1:0] in_data = '0;
    logic          overflow_clr = 1'b0;
    logic          full, empty, overflow, tx_enable, tx_write, sent_pulse, stall_err;
    logic [CW-1:0] count;
    logic [NB-1:0] tx_data;
    logic          tx_busy = 1'b0;
    logic          tx_done = 1'b0;
    logic          tx_error = 1'b0;

    uart_tx_feeder #(.DEPTH(DEPTH), .NUM_DATA_BITS(NB)) dut (
        .baud(baud), .rst_n(rst_n), .enable(enable), .push(push), .in_data(in_data),
        .overflow_clr(overflow_clr), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .tx_enable(tx_enable), .tx_write(tx_write), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .sent_pulse(sent_pulse), .stall_err(stall_err)
    );

    always #5 baud = ~baud;

    logic [NB-1:0] expq[$];
    int  total = 0;
    int  bad = 0;
    int  writes = 0;
    int  sents = 0;
    bit  exp_ovf = 1'b0;
    bit  prev_wr = 1'b0;
    bit  xm_stall = 1'b0;
    int  xm_len = 4;
    int  xm_rem = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must carry the oldest byte still queued in the model.
    always @(posedge baud) begin : mon
        logic [NB-1:0] e;
        #1;
        if (rst_n) begin
            if (tx_write) begin
                writes++;
                chk("tx_write_one_cycle", 32'(prev_wr), 32'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("tx_data_order", 32'(tx_data), 32'(e));
                end
            end
            if (sent_pulse) sents++;
        end
        prev_wr = tx_write;
    end

    // Transmitter model: busy for xm_len cycles after a write, then a done pulse.
    always @(posedge baud) begin
        #3;
        if (!rst_n) begin
            xm_rem  = 0;
            tx_busy = 1'b0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (xm_rem > 0) begin
                xm_rem--;
                if (xm_rem == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end
            if (tx_write && !xm_stall) begin
                xm_rem  = xm_len;
                tx_busy = 1'b1;
            end
        end
    end

    // One cycle of stimulus; called at 2 time units after a rising edge.
    task automatic step(input bit p = 1'b0, input logic [NB-1:0] d = '0,
                        input bit clr = 1'b0, input bit err = 1'b0);
        int occ;
        occ = expq.size();
        push = p; in_data = d; overflow_clr = clr; tx_error = err;
        if (p && occ >= int'(DEPTH)) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        if (p && occ < int'(DEPTH)) expq.push_back(d);
        @(posedge baud);
        #2;
        push = 1'b0; overflow_clr = 1'b0; tx_error = 1'b0;
        chk("count", 32'(count), 32'(expq.size()));
        chk("full", 32'(full), 32'(expq.size() == int'(DEPTH)));
        chk("empty", 32'(empty), 32'(expq.size() == 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_writes(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (writes < target && n < budget) begin step(); n++; end
        chk(nm, 32'(writes >= target), 32'd1);
    endtask

    task automatic wait_sents(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (sents < target && n < budget) begin step(); n++; end
        chk(nm, 32'(sents), 32'(target));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_empty"}, 32'(empty), 32'd1);
        chk({nm, "_full"}, 32'(full), 32'd0);
        chk({nm, "_count"}, 32'(count), 32'd0);
        chk({nm, "_overflow"}, 32'(overflow), 32'd0);
        chk({nm, "_stall"}, 32'(stall_err), 32'd0);
        chk({nm, "_tx_enable"}, 32'(tx_enable), 32'd0);
        chk({nm, "_tx_write"}, 32'(tx_write), 32'd0);
        chk({nm, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({nm, "_sent"}, 32'(sent_pulse), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_w, snap_s, target;

        #12;
        check_reset_outputs("reset");
        @(posedge baud); #2;
        rst_n = 1'b1;

        // Single byte through a cooperative transmitter.
        enable = 1'b1;
        snap_s = sents;
        step(1'b1, 8'hA5);
        wait_writes(1, 20, "s1_write");
        wait_sents(snap_s + 1, 30, "s1_sent");
        chk("s1_empty", 32'(empty), 32'd1);

        // Fill while disabled, overflow on the ninth push, then drain in order.
        enable = 1'b0;
        idle(2);
        for (int i = 1; i <= 8; i++) step(1'b1, NB'(i));
        chk("s2_full", 32'(full), 32'd1);
        chk("s2_count8", 32'(count), 32'd8);
        step(1'b1, 8'h09);
        chk("s2_overflow", 32'(overflow), 32'd1);
        chk("s2_count_after_drop", 32'(count), 32'd8);
        step(1'b0, '0, 1'b1);
        chk("s2_overflow_cleared", 32'(overflow), 32'd0);
        enable = 1'b1;
        snap_s = sents;
        wait_writes(writes + 8, 200, "s2_drain");
        wait_sents(snap_s + 8, 40, "s2_sent");

        // Push and pop in the same cycle leaves the count unchanged.
        enable = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b1, NB'(8'h31 + i));
        enable = 1'b1;
        step();
        step(1'b1, 8'h34);
        chk("s3_count_pushpop", 32'(count), 32'd3);
        chk("s3_write_on_pushpop", 32'(tx_write), 32'd1);
        target = writes + expq.size();
        wait_writes(target, 100, "s3_drain");

        // Random stream with gaps: pointers wrap repeatedly; drops follow the model.
        snap_w = writes;
        snap_s = sents;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, NB'($urandom));
            idle(int'($urandom_range(0, 3)));
        end
        target = writes + expq.size();
        wait_writes(target, 400, "s3_random_drain");
        wait_sents(snap_s + (writes - snap_w), 40, "s3_random_sent");
        step(1'b0, '0, 1'b1);

        // Transmitter never goes busy: stall two cycles after the issue cycle.
        xm_stall = 1'b1;
        snap_w = writes;
        step(1'b1, 8'h44);
        for (int n = 0; n < 10 && writes == snap_w; n++) step();
        chk("s4_write_seen", 32'(writes), 32'(snap_w + 1));
        step();
        step();
        chk("s4_stall_not_yet", 32'(stall_err), 32'd0);
        step();
        chk("s4_stall_set", 32'(stall_err), 32'd1);
        xm_stall = 1'b0;
        snap_s = sents;
        step(1'b1, 8'h45);
        wait_writes(snap_w + 2, 20, "s4_idle_again");
        wait_sents(snap_s + 1, 30, "s4_sent_after_stall");
        chk("s4_no_extra_sent", 32'(sents), 32'(snap_s + 1));
        step(1'b0, '0, 1'b1);
        chk("s4_stall_cleared", 32'(stall_err), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("tx_error_sets_stall", 32'(stall_err), 32'd1);
        step(1'b1, '0, 1'b1, 1'b1);
        chk("stall_set_beats_clear", 32'(stall_err), 32'd1);
        target = writes + expq.size();
        wait_writes(target, 30, "err_byte_drain");
        idle(8);
        step(1'b0, '0, 1'b1);
        chk("stall_cleared_again", 32'(stall_err), 32'd0);

        // Enable drops during WAIT_DONE with two bytes still queued.
        xm_len = 8;
        enable = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b1, NB'(8'h51 + i));
        enable = 1'b1;
        snap_w = writes;
        for (int n = 0; n < 10 && writes == snap_w; n++) step();
        chk("s5_first_write", 32'(writes), 32'(snap_w + 1));
        step();
        step();
        enable = 1'b0;
        snap_s = sents;
        snap_w = writes;
        idle(20);
        chk("s5_no_sent", 32'(sents), 32'(snap_s));
        chk("s5_no_write", 32'(writes), 32'(snap_w));
        chk("s5_count2", 32'(count), 32'd2);
        enable = 1'b1;
        wait_writes(snap_w + 2, 60, "s5_resume");
        wait_sents(snap_s + 2, 40, "s5_sent_two");
        xm_len = 4;

        // Asynchronous reset in the middle of a byte.
        for (int i = 0; i < 3; i++) step(1'b1, NB'(8'h61 + i));
        snap_w = writes;
        for (int n = 0; n < 10 && writes == snap_w; n++) step();
        step(1'b0, '0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s6_async");
        expq.delete();
        exp_ovf = 1'b0;
        @(posedge baud); #2;
        check_reset_outputs("s6_held");
        rst_n = 1'b1;
        snap_s = sents;
        step(1'b1, 8'h77);
        wait_writes(writes + 1, 20, "s6_after_reset");
        wait_sents(snap_s + 1, 30, "s6_sent");
        chk("s6_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
